// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: register offsets, CTRL/STATUS bit positions and reset values
// shared by the wb_timer RTL and the firmware header generator.
// Also holds the Wishbone byte-lane merge helper.
package wb_timer_pkg;

    // Word offsets, decoded from wb_adr_i[4:2]
    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_STATUS = 3'd1;
    localparam logic [2:0] ADR_COUNT  = 3'd2;
    localparam logic [2:0] ADR_CMP    = 3'd3;

    // CTRL bit positions
    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int CTRL_PSC_LSB     = 8;

    // STATUS bit positions
    localparam int STATUS_MATCH = 0;

    // Reset values
    localparam logic [31:0] CTRL_RESET   = 32'h0000_0000;
    localparam logic [31:0] STATUS_RESET = 32'h0000_0000;
    localparam logic [31:0] COUNT_RESET  = 32'h0000_0000;
    localparam logic [31:0] CMP_RESET    = 32'h0000_0000;

    // Replace the bytes of old_val whose lane enable is set
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// wb_timer_prescaler: divides HCLK by (psc+1) while enabled.
// Ports:
//   HCLK, HRESETn : clock, async active-low reset
//   en            : prescaler enable; when low the count is held at 0
//   restart       : forces the count back to 0 on the next edge
//   psc           : reload value, tick fires when the count reaches it
//   tick          : one-cycle count enable for the timer
module wb_timer_prescaler
    import wb_timer_pkg::*;
#(
    parameter int PSC_WIDTH = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 en,
    input  logic                 restart,
    input  logic [PSC_WIDTH-1:0] psc,
    output logic                 tick
);

    logic [PSC_WIDTH-1:0] pcnt;

    assign tick = en && (pcnt == psc);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pcnt <= '0;
        end else if (!en || restart || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_timer.sv
// wb_timer: 32-bit Wishbone-slave timer/compare unit with prescaler and a
// registered level interrupt.
// Ports:
//   HCLK, HRESETn      : clock, async active-low reset
//   wb_adr_i[4:2]      : register select (CTRL, STATUS, COUNT, CMP; rest unmapped)
//   wb_dat_i, wb_sel_i : write data and byte-lane enables
//   wb_we_i, wb_cyc_i, wb_stb_i : Wishbone control
//   wb_dat_o           : read data, non-zero only in the ack cycle
//   wb_ack_o           : one-cycle acknowledge, one cycle after the strobe
//   irq_o              : MATCH & IRQ_EN, registered
module wb_timer
    import wb_timer_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int PSC_WIDTH = 8
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq_o
);

    logic                 hs;
    logic                 wr;
    logic                 rd;
    logic [2:0]           reg_idx;

    logic                 en;
    logic                 auto_reload;
    logic                 irq_en;
    logic [PSC_WIDTH-1:0] psc;
    logic                 match;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] cmp;

    logic [31:0]          ctrl_rd;
    logic [31:0]          ctrl_merged;
    logic [31:0]          rdata;
    logic                 wr_ctrl;
    logic                 wr_status;
    logic                 wr_count;
    logic                 wr_cmp;
    logic                 psc_restart;
    logic                 tick;
    logic                 match_now;
    logic                 match_clr;
    logic                 unused_bits;

    // A transfer is accepted on the edge that raises ack
    assign hs      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr      = hs & wb_we_i;
    assign rd      = hs & ~wb_we_i;
    assign reg_idx = wb_adr_i[4:2];

    assign wr_ctrl   = wr && (reg_idx == ADR_CTRL);
    assign wr_status = wr && (reg_idx == ADR_STATUS);
    assign wr_count  = wr && (reg_idx == ADR_COUNT);
    assign wr_cmp    = wr && (reg_idx == ADR_CMP);

    always_comb begin
        ctrl_rd                               = '0;
        ctrl_rd[CTRL_EN]                      = en;
        ctrl_rd[CTRL_AUTO_RELOAD]             = auto_reload;
        ctrl_rd[CTRL_IRQ_EN]                  = irq_en;
        ctrl_rd[CTRL_PSC_LSB +: PSC_WIDTH]    = psc;
    end

    assign ctrl_merged = byte_merge(ctrl_rd, wb_dat_i, wb_sel_i);
    assign psc_restart = wr_ctrl && (ctrl_merged[CTRL_PSC_LSB +: PSC_WIDTH] != psc);

    always_comb begin
        rdata = '0;
        case (reg_idx)
            ADR_CTRL:   rdata = ctrl_rd;
            ADR_STATUS: rdata[STATUS_MATCH] = match;
            ADR_COUNT:  rdata = 32'(count);
            ADR_CMP:    rdata = 32'(cmp);
            default:    rdata = '0;
        endcase
    end

    wb_timer_prescaler #(
        .PSC_WIDTH (PSC_WIDTH)
    ) u_prescaler (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .en      (en),
        .restart (psc_restart),
        .psc     (psc),
        .tick    (tick)
    );

    assign match_now = tick && (count == cmp);
    assign match_clr = wr_status && wb_sel_i[0] && wb_dat_i[STATUS_MATCH];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= hs;
            wb_dat_o <= rd ? rdata : '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            en          <= CTRL_RESET[CTRL_EN];
            auto_reload <= CTRL_RESET[CTRL_AUTO_RELOAD];
            irq_en      <= CTRL_RESET[CTRL_IRQ_EN];
            psc         <= CTRL_RESET[CTRL_PSC_LSB +: PSC_WIDTH];
        end else if (wr_ctrl) begin
            en          <= ctrl_merged[CTRL_EN];
            auto_reload <= ctrl_merged[CTRL_AUTO_RELOAD];
            irq_en      <= ctrl_merged[CTRL_IRQ_EN];
            psc         <= ctrl_merged[CTRL_PSC_LSB +: PSC_WIDTH];
        end
    end

    // A software write to COUNT overrides the tick increment
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            count <= COUNT_RESET[CNT_WIDTH-1:0];
        end else if (wr_count) begin
            count <= CNT_WIDTH'(byte_merge(32'(count), wb_dat_i, wb_sel_i));
        end else if (tick) begin
            count <= (match_now && auto_reload) ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cmp <= CMP_RESET[CNT_WIDTH-1:0];
        end else if (wr_cmp) begin
            cmp <= CNT_WIDTH'(byte_merge(32'(cmp), wb_dat_i, wb_sel_i));
        end
    end

    // A new match outranks a simultaneous W1C
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            match <= STATUS_RESET[STATUS_MATCH];
        end else if (match_now) begin
            match <= 1'b1;
        end else if (match_clr) begin
            match <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= match & irq_en;
        end
    end

    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0],
                           ctrl_merged[31:CTRL_PSC_LSB+PSC_WIDTH], ctrl_merged[7:3]};

endmodule

// File: tb/tb_wb_timer.sv
module tb_wb_timer;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        irq_o;

    int n_assert = 0;
    int n_fail   = 0;

    wb_timer #(
        .CNT_WIDTH (32),
        .PSC_WIDTH (8)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .irq_o    (irq_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // ---------------- reference model ----------------
    // Register images as software sees them: [0]CTRL [1]STATUS [2]COUNT [3]CMP
    logic [31:0] m_reg [4];
    int unsigned m_pcnt;
    logic        m_ack;
    logic [31:0] m_dat;
    logic        m_irq;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
            m_pcnt = 0;
            m_ack  = 1'b0;
            m_dat  = 32'h0;
            m_irq  = 1'b0;
        end else begin
            logic        hs, tick, set, restart;
            int unsigned idx, psc;
            logic [31:0] n_ctrl, n_stat, n_cnt, n_cmp, rdat;
            hs      = wb_cyc_i && wb_stb_i && !m_ack;
            idx     = wb_adr_i[4:2];
            psc     = m_reg[0][15:8];
            tick    = m_reg[0][0] && (m_pcnt == psc);
            set     = tick && (m_reg[2] == m_reg[3]);
            restart = 1'b0;
            n_ctrl  = m_reg[0];
            n_stat  = set ? 32'h1 : m_reg[1];
            n_cnt   = m_reg[2];
            n_cmp   = m_reg[3];
            if (tick) n_cnt = (set && m_reg[0][1]) ? 32'h0 : m_reg[2] + 32'h1;
            rdat = 32'h0;
            if (hs && !wb_we_i && idx < 4) rdat = m_reg[idx];
            if (hs && wb_we_i) begin
                case (idx)
                    0: begin
                        n_ctrl  = merge(m_reg[0], wb_dat_i, wb_sel_i) & 32'h0000_FF07;
                        restart = (n_ctrl[15:8] != m_reg[0][15:8]);
                    end
                    1: if (wb_sel_i[0] && wb_dat_i[0] && !set) n_stat = 32'h0;
                    2: n_cnt = merge(m_reg[2], wb_dat_i, wb_sel_i);
                    3: n_cmp = merge(m_reg[3], wb_dat_i, wb_sel_i);
                    default: ;
                endcase
            end
            m_irq  = m_reg[1][0] && m_reg[0][2];
            m_pcnt = (!m_reg[0][0] || restart || tick) ? 0 : m_pcnt + 1;
            m_ack  = hs;
            m_dat  = rdat;
            m_reg[0] = n_ctrl;
            m_reg[1] = n_stat;
            m_reg[2] = n_cnt;
            m_reg[3] = n_cmp;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        if (HRESETn) begin
            check("ack", {31'h0, wb_ack_o}, {31'h0, m_ack});
            check("dat_o", wb_dat_o, m_dat);
            check("irq", {31'h0, irq_o}, {31'h0, m_irq});
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat);
        logic got;
        got      = 1'b0;
        rdat     = 32'h0;
        wb_adr_i = adr;
        wb_we_i  = we;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge HCLK);
            if (wb_ack_o) begin
                got  = 1'b1;
                rdat = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!got) begin
            n_assert++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack expected ack for adr %h", adr);
        end
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        bus(adr, 1'b1, dat, 4'hF, d);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] dat);
        bus(adr, 1'b0, 32'h0, 4'hF, dat);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  pat;

        HRESETn  = 1'b0;
        wb_adr_i = 32'h0;
        wb_dat_i = 32'h0;
        wb_sel_i = 4'h0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        idle(3);
        HRESETn = 1'b1;
        idle(1);

        // Reset values
        rd(32'h00, d); check("rst_ctrl", d, 32'h0);
        rd(32'h04, d); check("rst_status", d, 32'h0);
        rd(32'h08, d); check("rst_count", d, 32'h0);
        rd(32'h0C, d); check("rst_cmp", d, 32'h0);

        // Byte-lane write into CMP
        wr(32'h0C, 32'h1122_3344);
        bus(32'h0C, 1'b1, 32'h0000_AB00, 4'b0010, d);
        rd(32'h0C, d); check("byte_merge_cmp", d, 32'h1122_AB44);

        // Back-to-back reads of an unmapped offset with stb held
        idle(1);
        wb_adr_i = 32'h14; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1;   wb_stb_i = 1'b1;
        pat[0] = wb_ack_o;
        for (int i = 1; i < 4; i++) begin
            @(negedge HCLK);
            pat[i] = wb_ack_o;
            if (wb_ack_o) check("unmapped_read", wb_dat_o, 32'h0);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        check("b2b_ack_pattern", {28'h0, pat}, 32'h0000_000A);
        wr(32'h18, 32'hDEAD_BEEF);
        idle(2);

        // One-shot match at CMP=5 with interrupt
        wr(32'h00, 32'h0);
        wr(32'h08, 32'h0);
        wr(32'h0C, 32'h5);
        wr(32'h04, 32'h1);
        wr(32'h00, 32'h05);
        idle(12);
        rd(32'h04, d); check("oneshot_match", d, 32'h1);
        wr(32'h04, 32'h1);
        idle(3);

        // Prescaled auto-reload: poll COUNT continuously
        wr(32'h00, 32'h0);
        wr(32'h08, 32'h0);
        wr(32'h0C, 32'h2);
        wr(32'h00, 32'h0307);
        for (int i = 0; i < 20; i++) rd(32'h08, d);
        rd(32'h04, d); check("autoreload_match", d, 32'h1);

        // Wrap from all-ones: no match on wrap, match on the following tick
        wr(32'h00, 32'h0);
        wr(32'h08, 32'hFFFF_FFFF);
        wr(32'h0C, 32'h0);
        wr(32'h04, 32'h1);
        wr(32'h00, 32'h1);
        wr(32'h00, 32'h0);
        rd(32'h08, d); check("wrap_count", d, 32'h1);
        rd(32'h04, d); check("wrap_match", d, 32'h1);

        // W1C racing a match every cycle, then a clean W1C
        wr(32'h08, 32'h0);
        wr(32'h00, 32'h7);
        wr(32'h04, 32'h1);
        rd(32'h04, d); check("w1c_vs_set", d, 32'h1);
        wr(32'h00, 32'h4);
        wr(32'h04, 32'h1);
        rd(32'h04, d); check("w1c_clear", d, 32'h0);
        idle(3);

        // Randomized traffic
        for (int t = 0; t < 500; t++) begin
            int unsigned idx, kind;
            logic [31:0] dat;
            logic [3:0]  sel;
            idx  = $urandom_range(0, 7);
            kind = $urandom_range(0, 9);
            sel  = (kind < 7) ? 4'hF : 4'($urandom);
            case (idx)
                0: dat = {16'h0, 8'($urandom_range(0, 3)), 5'h0,
                          (kind == 0) ? 1'b0 : 1'($urandom), 1'($urandom), (kind < 8) ? 1'b1 : 1'b0};
                2: dat = (kind == 9) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                     : 32'($urandom_range(0, 15));
                3: dat = (kind == 9) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 15));
                default: dat = $urandom;
            endcase
            bus({27'h0, 3'(idx), 2'($urandom)}, 1'($urandom), dat, sel, d);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end

        // Reset asserted mid-read with irq high
        wr(32'h00, 32'h0);
        wr(32'h08, 32'h0);
        wr(32'h0C, 32'h0);
        wr(32'h00, 32'h7);
        idle(3);
        wb_adr_i = 32'h08; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1;   wb_stb_i = 1'b1;
        @(posedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        check("midrst_ack", {31'h0, wb_ack_o}, 32'h0);
        check("midrst_dat", wb_dat_o, 32'h0);
        check("midrst_irq", {31'h0, irq_o}, 32'h0);
        @(negedge HCLK);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        idle(1);
        HRESETn = 1'b1;
        idle(1);
        rd(32'h00, d); check("post_rst_ctrl", d, 32'h0);
        rd(32'h04, d); check("post_rst_status", d, 32'h0);
        rd(32'h08, d); check("post_rst_count", d, 32'h0);
        rd(32'h0C, d); check("post_rst_cmp", d, 32'h0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected completion before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
